// File: rtl/otbn_pkg.sv
// Shared types for the OTBN instruction-memory arbiter: controller state,
// response owner and the IMEM word width (32 data bits plus 7 integrity bits).
package otbn_pkg;

  localparam int ImemWordWidth = 39;

  typedef enum logic [1:0] {
    ImemStIdle = 2'b00,
    ImemStExec = 2'b01,
    ImemStWipe = 2'b10
  } imem_state_e;

  typedef enum logic [1:0] {
    ImemOwnNone = 2'b00,
    ImemOwnCore = 2'b01,
    ImemOwnHost = 2'b10
  } imem_owner_e;

endpackage

// File: rtl/otbn_imem_arbiter_chk.sv
// Property checker for the IMEM arbiter: response ownership, read-only
// execution and wipe completion ordering.
module otbn_imem_arbiter_chk
  import otbn_pkg::*;
(
  input logic        clk_i,
  input logic        rst_ni,
  input imem_state_e state_i,
  input imem_owner_e owner_i,
  input logic        core_rsp_i,
  input logic        host_rsp_i,
  input logic        imem_write_i,
  input logic        wipe_busy_i,
  input logic        wipe_done_i
);

  a_one_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (owner_i inside {ImemOwnNone, ImemOwnCore, ImemOwnHost}) && !(core_rsp_i && host_rsp_i));

  a_no_exec_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == ImemStExec) |-> !imem_write_i);

  a_done_after_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wipe_done_i |-> $past(wipe_busy_i));

endmodule

// File: rtl/otbn_imem_wipe_ctr.sv
// Secure-wipe word counter: walks the IMEM from byte address 0 in 32-bit
// steps and presents the current random word while enabled.
module otbn_imem_wipe_ctr
  import otbn_pkg::*;
#(
  parameter int ImemSizeByte = 4096,
  localparam int ImemAddrWidth = $clog2(ImemSizeByte)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     en_i,
  input  logic [ImemWordWidth-1:0] rnd_data_i,
  output logic [ImemAddrWidth-1:0] addr_o,
  output logic [ImemWordWidth-1:0] wdata_o,
  output logic                     last_o
);

  localparam int CntWidth = ImemAddrWidth - 2;

  logic [CntWidth-1:0] cnt_r;

  // Word index; the wrap after the last word naturally leaves it at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (start_i) begin
      cnt_r <= '0;
    end else if (en_i) begin
      cnt_r <= cnt_r + CntWidth'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign addr_o  = {cnt_r, 2'b00};
  assign last_o  = en_i && (cnt_r == {CntWidth{1'b1}});
  assign wdata_o = en_i ? rnd_data_i : {ImemWordWidth{1'b0}};

endmodule

// File: rtl/otbn_imem_arbiter.sv
// Single-port IMEM arbiter: shares the SRAM between the core prefetcher, the
// host bus and the secure-wipe engine, and routes read data to its owner.
module otbn_imem_arbiter
  import otbn_pkg::*;
#(
  parameter int ImemSizeByte = 4096,
  localparam int ImemAddrWidth = $clog2(ImemSizeByte)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     core_busy_i,
  input  logic                     core_req_i,
  input  logic [ImemAddrWidth-1:0] core_addr_i,
  output logic [ImemWordWidth-1:0] core_rdata_o,
  output logic                     core_rvalid_o,
  input  logic                     host_req_i,
  input  logic                     host_write_i,
  input  logic [ImemAddrWidth-1:0] host_addr_i,
  input  logic [ImemWordWidth-1:0] host_wdata_i,
  output logic                     host_gnt_o,
  output logic [ImemWordWidth-1:0] host_rdata_o,
  output logic                     host_rvalid_o,
  output logic                     host_err_o,
  input  logic                     wipe_start_i,
  input  logic [ImemWordWidth-1:0] wipe_data_i,
  output logic                     wipe_busy_o,
  output logic                     wipe_done_o,
  output logic                     imem_req_o,
  output logic                     imem_write_o,
  output logic [ImemAddrWidth-1:0] imem_addr_o,
  output logic [ImemWordWidth-1:0] imem_wdata_o,
  input  logic [ImemWordWidth-1:0] imem_rdata_i,
  input  logic                     imem_rvalid_i
);

  imem_state_e state_r, state_s;
  imem_owner_e owner_r, owner_s;
  logic host_wack_r, host_wack_s;
  logic host_err_r, host_err_s;
  logic wipe_done_r, wipe_done_s;
  logic wipe_start_s, wipe_en_s, wipe_last_s;
  logic rsp_core_s, rsp_host_s;
  logic [ImemAddrWidth-1:0] wipe_addr_s;
  logic [ImemWordWidth-1:0] wipe_wdata_s;

  assign wipe_en_s    = (state_r == ImemStWipe);
  assign wipe_start_s = wipe_start_i && (state_r != ImemStWipe);

  otbn_imem_wipe_ctr #(
    .ImemSizeByte(ImemSizeByte)
  ) u_wipe_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (wipe_start_s),
    .en_i      (wipe_en_s),
    .rnd_data_i(wipe_data_i),
    .addr_o    (wipe_addr_s),
    .wdata_o   (wipe_wdata_s),
    .last_o    (wipe_last_s)
  );

  // Controller state and response bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ImemStIdle;
      owner_r     <= ImemOwnNone;
      host_wack_r <= 1'b0;
      host_err_r  <= 1'b0;
      wipe_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      host_wack_r <= host_wack_s;
      host_err_r  <= host_err_s;
      wipe_done_r <= wipe_done_s;
    end
  end

  // Next-state logic; a wipe request wins over everything outside Wipe
  always_comb begin
    state_s = state_r;
    case (state_r)
      ImemStIdle: begin
        if (wipe_start_i)     state_s = ImemStWipe;
        else if (core_busy_i) state_s = ImemStExec;
        else                  state_s = ImemStIdle;
      end
      ImemStExec: begin
        if (wipe_start_i)      state_s = ImemStWipe;
        else if (!core_busy_i) state_s = ImemStIdle;
        else                   state_s = ImemStExec;
      end
      ImemStWipe: begin
        if (wipe_last_s) state_s = ImemStIdle;
        else             state_s = ImemStWipe;
      end
      default: state_s = ImemStIdle;
    endcase
  end

  // SRAM port mux, host grant and next-cycle response bookkeeping
  always_comb begin
    imem_req_o   = 1'b0;
    imem_write_o = 1'b0;
    imem_addr_o  = {ImemAddrWidth{1'b0}};
    imem_wdata_o = {ImemWordWidth{1'b0}};
    host_gnt_o   = host_req_i;
    wipe_busy_o  = 1'b0;
    owner_s      = ImemOwnNone;
    host_wack_s  = 1'b0;
    host_err_s   = 1'b0;
    wipe_done_s  = 1'b0;
    case (state_r)
      ImemStIdle: begin
        imem_req_o   = host_req_i;
        imem_write_o = host_req_i && host_write_i;
        imem_addr_o  = host_req_i ? host_addr_i : {ImemAddrWidth{1'b0}};
        imem_wdata_o = (host_req_i && host_write_i) ? host_wdata_i : {ImemWordWidth{1'b0}};
        owner_s      = (host_req_i && !host_write_i) ? ImemOwnHost : ImemOwnNone;
        host_wack_s  = host_req_i && host_write_i;
      end
      ImemStExec: begin
        imem_req_o  = core_req_i;
        imem_addr_o = core_req_i ? core_addr_i : {ImemAddrWidth{1'b0}};
        owner_s     = core_req_i ? ImemOwnCore : ImemOwnNone;
        host_err_s  = host_req_i;
      end
      ImemStWipe: begin
        imem_req_o   = 1'b1;
        imem_write_o = 1'b1;
        imem_addr_o  = wipe_addr_s;
        imem_wdata_o = wipe_wdata_s;
        wipe_busy_o  = 1'b1;
        host_err_s   = host_req_i;
        wipe_done_s  = wipe_last_s;
      end
      default: begin
        host_gnt_o = 1'b0;
      end
    endcase
  end

  // A core read still in flight when the wipe begins is dropped.
  assign rsp_core_s = imem_rvalid_i && (owner_r == ImemOwnCore) && (state_r != ImemStWipe);
  assign rsp_host_s = imem_rvalid_i && (owner_r == ImemOwnHost);

  assign core_rvalid_o = rsp_core_s;
  assign core_rdata_o  = rsp_core_s ? imem_rdata_i : {ImemWordWidth{1'b0}};
  assign host_rvalid_o = rsp_host_s || host_wack_r || host_err_r;
  assign host_err_o    = host_err_r;
  assign host_rdata_o  = rsp_host_s ? imem_rdata_i : {ImemWordWidth{1'b0}};
  assign wipe_done_o   = wipe_done_r;

  otbn_imem_arbiter_chk u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .state_i     (state_r),
    .owner_i     (owner_r),
    .core_rsp_i  (rsp_core_s),
    .host_rsp_i  (rsp_host_s),
    .imem_write_i(imem_write_o),
    .wipe_busy_i (wipe_busy_o),
    .wipe_done_i (wipe_done_o)
  );

endmodule
